// File: rtl/stack_access_unit_pkg.sv
// Shared definitions for the stack access unit: FSM encoding, opcodes and defaults.
package stack_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WB    = 2'd2,
        FAULT = 2'd3
    } sau_state_t;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam int unsigned DEFAULT_STACK_STEP     = 4;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/stack_access_unit_if.sv
// Data-memory request/acknowledge bus between the stack access unit and memory.
interface stack_access_unit_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/stack_timeout_counter.sv
// Wait-cycle counter for a pending memory request; terminal flags the cycle
// whose increment would make the count reach TERMINAL.
module stack_timeout_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TERMINAL = 255
) (
    input  logic clock_5,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [WIDTH-1:0] LAST_STEP = WIDTH'(TERMINAL - 1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock_5 or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = enable && (count == LAST_STEP);

endmodule

// File: rtl/stack_access_unit.sv
// PUSH/POP engine: computes the stack address, runs the memory handshake and
// writes the updated ESP back. Optional bounds checking: STACK_BOUNDS_CHECK_EN.
module stack_access_unit
    import stack_access_unit_pkg::*;
#(
    parameter int unsigned STACK_STEP     = DEFAULT_STACK_STEP,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0] STACK_BASE     = 32'h0000_1000,
    parameter logic [31:0] STACK_LIMIT    = 32'h0000_0800
) (
    input  logic                       clock_5,
    input  logic                       reset,
    input  logic                       cmd_valid,
    input  logic                       cmd_op,
    output logic                       cmd_ready,
    input  logic [31:0]                push_data,
    input  logic [31:0]                esp_in,
    output logic                       esp_wr_en,
    output logic [31:0]                esp_wr_data,
    stack_access_unit_if.master        mem,
    output logic                       pop_valid,
    output logic [31:0]                pop_data,
    output logic                       fault
);

    localparam logic [31:0] STEP = 32'(STACK_STEP);

    sau_state_t  state_q;
    sau_state_t  state_d;
    logic        op_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] new_esp_q;
    logic [31:0] pop_data_q;
    logic        mem_req_c;
    logic        accept;
    logic        bounds_err;
    logic        timeout_hit;

    assign accept = (state_q == IDLE) && cmd_valid;

`ifdef STACK_BOUNDS_CHECK_EN
    // Compared in 33 bits so that a wrapping push or pop counts as out of range.
    logic [32:0] push_floor;
    logic [32:0] pop_top;
    assign push_floor = {1'b0, STACK_LIMIT} + {1'b0, STEP};
    assign pop_top    = {1'b0, esp_in} + {1'b0, STEP};
    assign bounds_err = (cmd_op == OP_PUSH) ? ({1'b0, esp_in} < push_floor)
                                            : (pop_top > {1'b0, STACK_BASE});
`else
    logic unused_bounds;
    assign unused_bounds = ^{STACK_BASE, STACK_LIMIT};
    assign bounds_err    = 1'b0;
`endif

    stack_timeout_counter #(
        .WIDTH    (8),
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock_5  (clock_5),
        .reset    (reset),
        .clear    (state_q != REQ),
        .enable   ((state_q == REQ) && !mem.mem_ack),
        .terminal (timeout_hit)
    );

    always_ff @(posedge clock_5 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs are pure state decodes so reset removes mem_req at once.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        mem_req_c = 1'b0;
        esp_wr_en = 1'b0;
        pop_valid = 1'b0;
        fault     = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (accept) begin
                    state_d = bounds_err ? FAULT : REQ;
                end
            end
            REQ: begin
                mem_req_c = 1'b1;
                if (mem.mem_ack) begin
                    state_d = WB;
                end else if (timeout_hit) begin
                    state_d = FAULT;
                end
            end
            WB: begin
                esp_wr_en = 1'b1;
                pop_valid = (op_q == OP_POP);
                state_d   = IDLE;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operation registers are loaded once at accept; esp_in is not looked at again.
    always_ff @(posedge clock_5 or posedge reset) begin
        if (reset) begin
            op_q       <= OP_PUSH;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            new_esp_q  <= '0;
            pop_data_q <= '0;
        end else begin
            if (accept && !bounds_err) begin
                op_q <= cmd_op;
                if (cmd_op == OP_PUSH) begin
                    we_q      <= 1'b1;
                    addr_q    <= esp_in - STEP;
                    new_esp_q <= esp_in - STEP;
                    wdata_q   <= push_data;
                end else begin
                    we_q      <= 1'b0;
                    addr_q    <= esp_in;
                    new_esp_q <= esp_in + STEP;
                end
            end
            if ((state_q == REQ) && mem.mem_ack && (op_q == OP_POP)) begin
                pop_data_q <= mem.mem_rdata;
            end
        end
    end

    assign mem.mem_req   = mem_req_c;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign esp_wr_data   = new_esp_q;
    assign pop_data      = pop_data_q;

endmodule

// File: tb/tb_stack_access_unit.sv
// Self-checking bench for stack_access_unit: cycle-level expectations derived
// from the PUSH/POP rules, randomized operations, plus literal pins.
`timescale 1ns/1ps
module tb_stack_access_unit;
    import stack_access_unit_pkg::*;

    localparam logic [31:0] STEP    = 32'd4;
    localparam logic [31:0] BASE    = 32'h0000_1000;
    localparam logic [31:0] LIMIT   = 32'h0000_0800;
    localparam int          TIMEOUT = 255;

    logic        clock_5 = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_op;
    logic        cmd_ready;
    logic [31:0] push_data;
    logic [31:0] esp_in;
    logic        esp_wr_en;
    logic [31:0] esp_wr_data;
    logic        pop_valid;
    logic [31:0] pop_data;
    logic        fault;

    stack_access_unit_if mem_bus ();

    stack_access_unit dut (
        .clock_5     (clock_5),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_ready   (cmd_ready),
        .push_data   (push_data),
        .esp_in      (esp_in),
        .esp_wr_en   (esp_wr_en),
        .esp_wr_data (esp_wr_data),
        .mem         (mem_bus),
        .pop_valid   (pop_valid),
        .pop_data    (pop_data),
        .fault       (fault)
    );

    always #5 clock_5 = ~clock_5;

    int checks = 0;
    int failures = 0;
    int wr_pulses = 0;
    int expected_wr = 0;

    // Expected output values for the current cycle, set by the stimulus side.
    bit          check_en = 1'b0;
    logic        exp_ready, exp_req, exp_we, exp_wr_en, exp_pop_valid, exp_fault;
    logic [31:0] exp_addr, exp_wdata, exp_wr_data, exp_pop_data;
    logic [31:0] model_pop = '0;

    logic [31:0] last_addr, last_wdata, last_wr_data;
    logic        last_we;

    task automatic check_word(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock_5) begin
        if (check_en) begin
            check_bit("cmd_ready", cmd_ready, exp_ready);
            check_bit("mem_req", mem_bus.mem_req, exp_req);
            check_bit("esp_wr_en", esp_wr_en, exp_wr_en);
            check_bit("pop_valid", pop_valid, exp_pop_valid);
            check_bit("fault", fault, exp_fault);
            check_word("pop_data", pop_data, exp_pop_data);
            if (exp_req) begin
                check_word("mem_addr", mem_bus.mem_addr, exp_addr);
                check_bit("mem_we", mem_bus.mem_we, exp_we);
                if (exp_we) check_word("mem_wdata", mem_bus.mem_wdata, exp_wdata);
            end
            if (exp_wr_en) check_word("esp_wr_data", esp_wr_data, exp_wr_data);
        end
    end

    always @(negedge clock_5) begin
        if (esp_wr_en === 1'b1) begin
            wr_pulses++;
            last_wr_data = esp_wr_data;
        end
        if (mem_bus.mem_req === 1'b1) begin
            last_addr  = mem_bus.mem_addr;
            last_wdata = mem_bus.mem_wdata;
            last_we    = mem_bus.mem_we;
        end
    end

    task automatic expect_idle();
        exp_ready = 1'b1; exp_req = 1'b0; exp_wr_en = 1'b0;
        exp_pop_valid = 1'b0; exp_fault = 1'b0; exp_pop_data = model_pop;
    endtask

    task automatic expect_fault();
        exp_ready = 1'b0; exp_req = 1'b0; exp_wr_en = 1'b0;
        exp_pop_valid = 1'b0; exp_fault = 1'b1; exp_pop_data = model_pop;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock_5); #1;
            cmd_valid = 1'b0;
            mem_bus.mem_ack = 1'($urandom_range(0, 1));
            mem_bus.mem_rdata = $urandom;
            expect_idle();
        end
    endtask

    task automatic do_reset();
        @(posedge clock_5); #1;
        check_en = 1'b0;
        reset = 1'b1;
        cmd_valid = 1'b0;
        mem_bus.mem_ack = 1'b0;
        model_pop = '0;
        repeat (2) @(posedge clock_5);
        #1 reset = 1'b0;
        expect_idle();
        check_en = 1'b1;
    endtask

    // One command: cycle 0 presents it, then wait_cycles+1 REQ cycles, then WB.
    task automatic apply_stimulus(input logic op, input logic [31:0] esp, input logic [31:0] data,
                                  input logic [31:0] rdata, input int wait_cycles, input bit never_ack);
        logic [31:0] addr;
        logic [31:0] new_esp;
        bit          err;
        bit          ack_now;
        addr    = (op == OP_PUSH) ? esp - STEP : esp;
        new_esp = (op == OP_PUSH) ? esp - STEP : esp + STEP;
        err     = 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
        if (op == OP_PUSH) err = (longint'(esp) - 4 < longint'(LIMIT));
        else               err = (longint'(esp) + 4 > longint'(BASE));
`endif
        @(posedge clock_5); #1;
        cmd_valid = 1'b1; cmd_op = op; esp_in = esp; push_data = data;
        mem_bus.mem_ack = 1'($urandom_range(0, 1));
        mem_bus.mem_rdata = $urandom;
        expect_idle();
        if (err) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clock_5); #1;
                cmd_valid = 1'($urandom_range(0, 1)); esp_in = $urandom;
                mem_bus.mem_ack = 1'($urandom_range(0, 1));
                expect_fault();
            end
            return;
        end
        for (int k = 1; k <= wait_cycles + 1; k++) begin
            @(posedge clock_5); #1;
            cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 1'($urandom);
            esp_in = $urandom; push_data = $urandom;
            ack_now = (k == wait_cycles + 1) && !never_ack;
            mem_bus.mem_ack = ack_now;
            mem_bus.mem_rdata = ack_now ? rdata : $urandom;
            exp_ready = 1'b0; exp_req = 1'b1; exp_addr = addr; exp_we = (op == OP_PUSH);
            exp_wdata = data; exp_wr_en = 1'b0; exp_pop_valid = 1'b0; exp_fault = 1'b0;
            exp_pop_data = model_pop;
        end
        if (never_ack) begin
            for (int i = 0; i < 4; i++) begin
                @(posedge clock_5); #1;
                cmd_valid = 1'($urandom_range(0, 1));
                mem_bus.mem_ack = 1'($urandom_range(0, 1));
                expect_fault();
            end
            return;
        end
        @(posedge clock_5); #1;
        cmd_valid = 1'($urandom_range(0, 1)); esp_in = $urandom;
        mem_bus.mem_ack = 1'($urandom_range(0, 1));
        mem_bus.mem_rdata = $urandom;
        if (op == OP_POP) model_pop = rdata;
        exp_ready = 1'b0; exp_req = 1'b0; exp_wr_en = 1'b1; exp_wr_data = new_esp;
        exp_pop_valid = (op == OP_POP); exp_fault = 1'b0; exp_pop_data = model_pop;
        expected_wr++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_op = OP_PUSH; push_data = '0; esp_in = '0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        repeat (2) @(posedge clock_5);
        #1;
        check_bit("reset_cmd_ready", cmd_ready, 1'b1);
        check_bit("reset_mem_req", mem_bus.mem_req, 1'b0);
        check_bit("reset_fault", fault, 1'b0);
        check_bit("reset_esp_wr_en", esp_wr_en, 1'b0);
        check_bit("reset_pop_valid", pop_valid, 1'b0);
        check_word("reset_pop_data", pop_data, 32'h0);
        check_word("reset_esp_wr_data", esp_wr_data, 32'h0);
        check_word("reset_mem_addr", mem_bus.mem_addr, 32'h0);
        reset = 1'b0;
        expect_idle();
        check_en = 1'b1;
        idle_cycles(2);

        $display("[TB] directed push, immediate ack");
        apply_stimulus(OP_PUSH, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
        idle_cycles(1);
        check_word("push_addr_literal", last_addr, 32'h0000_0FFC);
        check_word("push_wdata_literal", last_wdata, 32'hDEAD_BEEF);
        check_bit("push_we_literal", last_we, 1'b1);
        check_word("push_esp_literal", last_wr_data, 32'h0000_0FFC);

        $display("[TB] directed pop, three wait cycles");
        apply_stimulus(OP_POP, 32'h0000_0FFC, 32'h0, 32'h1234_5678, 3, 1'b0);
        idle_cycles(1);
        check_word("pop_data_literal", pop_data, 32'h1234_5678);
        check_word("pop_esp_literal", last_wr_data, 32'h0000_1000);

        $display("[TB] randomized operations");
        for (int n = 0; n < 40; n++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 32'h0000_0804 + 4 * $urandom_range(0, 510),
                           $urandom, $urandom, $urandom_range(0, 5), 1'b0);
            idle_cycles($urandom_range(0, 2));
        end

        $display("[TB] wrap-around push at ESP 0");
        apply_stimulus(OP_PUSH, 32'h0, 32'hA5A5_0001, 32'h0, 1, 1'b0);
`ifdef STACK_BOUNDS_CHECK_EN
        check_bit("wrap_fault_literal", fault, 1'b1);
        do_reset();
`else
        idle_cycles(1);
        check_word("wrap_addr_literal", last_addr, 32'hFFFF_FFFC);
        check_word("wrap_esp_literal", last_wr_data, 32'hFFFF_FFFC);
`endif

        $display("[TB] timeout with no acknowledge");
        apply_stimulus(OP_PUSH, 32'h0000_1000, 32'h0BAD_F00D, 32'h0, TIMEOUT - 1, 1'b1);
        check_bit("timeout_fault_literal", fault, 1'b1);
        check_bit("timeout_ready_literal", cmd_ready, 1'b0);
        do_reset();

        $display("[TB] reset in the middle of a request");
        @(posedge clock_5); #1;
        cmd_valid = 1'b1; cmd_op = OP_PUSH; esp_in = 32'h0000_0F00; push_data = 32'h1111_2222;
        mem_bus.mem_ack = 1'b0;
        expect_idle();
        @(posedge clock_5); #1;
        cmd_valid = 1'b0;
        check_en = 1'b0;
        #6;
        check_bit("req_before_reset", mem_bus.mem_req, 1'b1);
        reset = 1'b1;
        #1;
        check_bit("req_async_drop", mem_bus.mem_req, 1'b0);
        model_pop = '0;
        repeat (2) @(posedge clock_5);
        #1 reset = 1'b0;
        check_bit("post_reset_ready", cmd_ready, 1'b1);
        check_bit("post_reset_fault", fault, 1'b0);
        expect_idle();
        check_en = 1'b1;
        rd = $urandom;
        apply_stimulus(OP_POP, 32'h0000_0FF8, 32'h0, rd, 2, 1'b0);
        idle_cycles(1);
        check_word("post_reset_pop_literal", pop_data, rd);
        check_word("post_reset_esp_literal", last_wr_data, 32'h0000_0FFC);

        idle_cycles(2);
        check_en = 1'b0;
        check_word("wr_pulse_count", 32'(wr_pulses), 32'(expected_wr));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
